// File: rtl/regfile_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter_if
// Bundles the signals between the read arbiter, its requesters and the
// register-file read mux bank.
//   req      : per-requester read request level
//   req_addr : packed register indices, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   rf_sel   : select driven to the mux bank
//   rf_data  : combinational mux-bank output for rf_sel
//   gnt      : one-hot grant
//   rvalid   : one-hot read-data-valid pulse
//   rdata    : captured register word
//   busy     : high while a grant or a read-data pulse is outstanding
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding agents and the mux bank.
// -----------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0]         rf_sel;
  logic [DATA_WIDTH-1:0]         rf_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          busy;

  modport master (
    output req, req_addr, rf_data,
    input  rf_sel, gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, req_addr, rf_data,
    output rf_sel, gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
// Shares one register-file read port among NUM_REQ requesters using
// round-robin arbitration, with a two-stage pipeline:
//   edge k   : arbitrate, register one-hot grant, select and pointer
//   cycle k+1: grant and select are driven, mux bank returns rf_data
//   edge k+1 : capture rf_data and raise the winner's rvalid bit
// A new arbitration and a capture for the previous winner can share an edge.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   bus   : slave view of regfile_read_arbiter_if (req/req_addr/rf_data in,
//           rf_sel/gnt/rvalid/rdata/busy out)
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] sel_q, sel_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    eligible_s;
  logic [PTR_W-1:0]      win_s;
  logic [PTR_W-1:0]      idx_s;
  logic                  found_s;
  int                    sum_s;

  // Round-robin search: first eligible requester starting at ptr_q, wrapping.
  always_comb begin
    // The requester currently holding the grant sits out this edge, so a
    // requester can win at most once every two cycles.
    eligible_s = bus.req & ~gnt_q;
    found_s    = 1'b0;
    win_s      = {PTR_W{1'b0}};
    idx_s      = {PTR_W{1'b0}};
    sum_s      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s = int'(ptr_q) + i;
      idx_s = (sum_s >= NUM_REQ) ? PTR_W'(sum_s - NUM_REQ) : PTR_W'(sum_s);
      if (!found_s && eligible_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state for grant, select, pointer, capture stage and busy.
  always_comb begin
    gnt_d = {NUM_REQ{1'b0}};
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (found_s) begin
      gnt_d[win_s] = 1'b1;
      // Only the winner's address reaches sel_d; losers' addresses may be X.
      for (int r = 0; r < NUM_REQ; r++) begin
        if (win_s == PTR_W'(r)) begin
          sel_d = bus.req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
          sel_d = sel_d;
        end
      end
      ptr_d = (win_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (win_s + PTR_W'(1));
    end else begin
      sel_d = sel_q;
      ptr_d = ptr_q;
    end

    // Capture is driven purely by last edge's grant, independent of the
    // arbitration happening at the same edge.
    if (|gnt_q) begin
      rvalid_d = gnt_q;
      rdata_d  = bus.rf_data;
    end else begin
      rvalid_d = {NUM_REQ{1'b0}};
      rdata_d  = rdata_q;
    end

    // busy is registered from the same next-state values so it tracks
    // |gnt_q | |rvalid_q exactly.
    busy_d = (|gnt_d) | (|rvalid_d);
  end

  // State registers with synchronous reset; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= {NUM_REQ{1'b0}};
      rvalid_q <= {NUM_REQ{1'b0}};
      sel_q    <= {ADDR_WIDTH{1'b0}};
      ptr_q    <= {PTR_W{1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rf_sel = sel_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;

endmodule
